// File: rtl/d16_hazard_unit_pkg.sv
// Shared d16 definitions: opcode encodings, default widths, op-class record.
// Pure declarations; no logic, no latency, no flow control.
// Opcode 0 is the bubble and decodes to no reads and no write.
package d16_hazard_unit_pkg;

    localparam int D16_OP_W    = 8;
    localparam int D16_FIELD_W = 16;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_ADD = 8'h01;
    localparam logic [7:0] OP_SUB = 8'h02;
    localparam logic [7:0] OP_SHL = 8'h03;
    localparam logic [7:0] OP_SHR = 8'h04;
    localparam logic [7:0] OP_EQU = 8'h05;
    localparam logic [7:0] OP_STP = 8'h06;
    localparam logic [7:0] OP_JMZ = 8'h07;
    localparam logic [7:0] OP_COP = 8'h08;
    localparam logic [7:0] OP_STR = 8'h09;
    localparam logic [7:0] OP_AFC = 8'h0A;
    localparam logic [7:0] OP_LOD = 8'h0B;
    localparam logic [7:0] OP_LOP = 8'h0C;

    typedef struct packed {
        logic reads_b;
        logic reads_c;
        logic writer;
        logic load;
    } op_class_t;

endpackage

// File: rtl/d16_hazard_unit_if.sv
// LI/DI-side bus of the hazard unit: incoming op fields plus stall/forward results.
// Wires only; master drives the op, slave (hazard unit) returns en/fwd/stall_cnt.
// Backpressure is the en signal itself: en=0 holds the front end.
interface d16_hazard_unit_if #(
    parameter int OP_W    = 8,
    parameter int FIELD_W = 16,
    parameter int DEPTH   = 3
);
    localparam int FWD_W = $clog2(DEPTH + 1);

    logic [OP_W-1:0]    li_di_op;
    logic [FIELD_W-1:0] li_di_a;
    logic [FIELD_W-1:0] li_di_b;
    logic [FIELD_W-1:0] li_di_c;
    logic               jmp;
    logic [OP_W-1:0]    li_di_op_out;
    logic               en;
    logic [FWD_W-1:0]   fwd_b;
    logic [FWD_W-1:0]   fwd_c;
    logic [15:0]        stall_cnt;

    modport master (
        output li_di_op, li_di_a, li_di_b, li_di_c, jmp,
        input  li_di_op_out, en, fwd_b, fwd_c, stall_cnt
    );

    modport slave (
        input  li_di_op, li_di_a, li_di_b, li_di_c, jmp,
        output li_di_op_out, en, fwd_b, fwd_c, stall_cnt
    );

endinterface

// File: rtl/d16_op_class.sv
// Opcode decoder: which source fields an op reads, whether it writes, whether it loads.
// Purely combinational, zero latency.
// No flow control; follows its input every cycle.
module d16_op_class
    import d16_hazard_unit_pkg::*;
#(
    parameter int OP_W = D16_OP_W
) (
    input  logic [OP_W-1:0] op,
    output op_class_t       cls
);

    always_comb begin
        cls = '0;
        case (op)
            OP_W'(OP_ADD), OP_W'(OP_SUB), OP_W'(OP_SHL),
            OP_W'(OP_SHR), OP_W'(OP_EQU): begin
                cls.reads_b = 1'b1;
                cls.reads_c = 1'b1;
                cls.writer  = 1'b1;
            end
            OP_W'(OP_STP): begin
                cls.reads_b = 1'b1;
                cls.reads_c = 1'b1;
            end
            OP_W'(OP_JMZ), OP_W'(OP_STR): begin
                cls.reads_b = 1'b1;
            end
            OP_W'(OP_COP): begin
                cls.reads_b = 1'b1;
                cls.writer  = 1'b1;
            end
            OP_W'(OP_AFC): begin
                cls.writer  = 1'b1;
            end
            OP_W'(OP_LOD), OP_W'(OP_LOP): begin
                cls.writer  = 1'b1;
                cls.load    = 1'b1;
            end
            default: cls = '0;
        endcase
    end

endmodule

// File: rtl/d16_hazard_unit.sv
// Hazard detect + forward select at LI/DI, tracking in-flight writes in a DEPTH shift register.
// en/li_di_op_out/fwd_* are same-cycle combinational; tracker and stall_cnt update on sys_clk.
// Stalls the front end (en=0, bubble out) on a blocking source match; jmp overrides. Macro: D16_FORWARD_EN.
module d16_hazard_unit
    import d16_hazard_unit_pkg::*;
#(
    parameter int OP_W       = D16_OP_W,
    parameter int FIELD_W    = D16_FIELD_W,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    d16_hazard_unit_if.slave bus
);

    typedef struct packed {
        logic               valid;
        logic               load;
        logic [FIELD_W-1:0] dest;
    } trk_entry_t;

    trk_entry_t [DEPTH-1:0] st;
    op_class_t              cls_in;
    op_class_t              cls_out;
    logic [OP_W-1:0]        op_out;
    logic                   en_w;
    logic [DEPTH-1:0]       hit_b;
    logic [DEPTH-1:0]       hit_c;
    logic [DEPTH-1:0]       blk;
    logic [15:0]            stall_cnt;
    logic                   unused_cls;

    // Incoming op decides what is read; the op actually passed on decides what gets recorded.
    d16_op_class #(.OP_W(OP_W)) u_cls_in  (.op(bus.li_di_op), .cls(cls_in));
    d16_op_class #(.OP_W(OP_W)) u_cls_out (.op(op_out),       .cls(cls_out));

    always_comb begin
        hit_b = '0;
        hit_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_b[i] = cls_in.reads_b && st[i].valid && (st[i].dest == bus.li_di_b);
            hit_c[i] = cls_in.reads_c && st[i].valid && (st[i].dest == bus.li_di_c);
        end
    end

`ifdef D16_FORWARD_EN
    localparam int FWD_W = $clog2(DEPTH + 1);

    logic [FWD_W-1:0] sel_b;
    logic [FWD_W-1:0] sel_c;

    // Only a load that has not yet reached its forwardable stage can block.
    always_comb begin
        blk = '0;
        for (int i = 0; i < DEPTH; i++) begin
            blk[i] = st[i].load && (i < LOAD_STAGE) && (hit_b[i] || hit_c[i]);
        end
    end

    // Scan oldest to youngest so the youngest producer overwrites the selection.
    always_comb begin
        sel_b = '0;
        sel_c = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hit_b[i]) sel_b = FWD_W'(i + 1);
            if (hit_c[i]) sel_c = FWD_W'(i + 1);
        end
    end

    assign bus.fwd_b = en_w ? sel_b : '0;
    assign bus.fwd_c = en_w ? sel_c : '0;
`else
    logic [DEPTH-1:0] unused_load;
    logic [31:0]      unused_cfg;

    assign blk         = hit_b | hit_c;
    assign bus.fwd_b   = '0;
    assign bus.fwd_c   = '0;
    assign unused_cfg  = 32'(LOAD_STAGE);

    always_comb begin
        unused_load = '0;
        for (int i = 0; i < DEPTH; i++) unused_load[i] = st[i].load;
    end
`endif

    assign en_w             = bus.jmp || (blk == '0);
    assign op_out           = en_w ? bus.li_di_op : '0;
    assign bus.en           = en_w;
    assign bus.li_di_op_out = op_out;
    assign bus.stall_cnt    = stall_cnt;
    assign unused_cls       = ^{cls_in.writer, cls_in.load, cls_out.reads_b, cls_out.reads_c};

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            st        <= '0;
            stall_cnt <= '0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) st[i] <= st[i-1];
            st[0] <= trk_entry_t'{valid: cls_out.writer, load: cls_out.load, dest: bus.li_di_a};
            if (!en_w && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_d16_hazard_unit.sv
// Directed bench for d16_hazard_unit: ALU/load dependencies, jmp override, reset mid-stall,
// and stall_cnt saturation on a deep second instance. Expectations follow D16_FORWARD_EN.
module tb_d16_hazard_unit;
    import d16_hazard_unit_pkg::*;

`ifdef D16_FORWARD_EN
    localparam int         ALU_STALLS  = 0;
    localparam int         LOAD_STALLS = 2;
    localparam logic [1:0] FWD_ALU0    = 2'd1;
    localparam logic [1:0] FWD_LOAD2   = 2'd3;
`else
    localparam int         ALU_STALLS  = 3;
    localparam int         LOAD_STALLS = 3;
    localparam logic [1:0] FWD_ALU0    = 2'd0;
    localparam logic [1:0] FWD_LOAD2   = 2'd0;
`endif

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    always #5 sys_clk = ~sys_clk;

    d16_hazard_unit_if #(.OP_W(8), .FIELD_W(16), .DEPTH(3))  bus  ();
    d16_hazard_unit_if #(.OP_W(8), .FIELD_W(16), .DEPTH(31)) bus2 ();

    d16_hazard_unit #(.OP_W(8), .FIELD_W(16), .DEPTH(3), .LOAD_STAGE(2)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    d16_hazard_unit #(.OP_W(8), .FIELD_W(16), .DEPTH(31), .LOAD_STAGE(30)) dut_sat (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus2)
    );

    typedef struct packed {
        logic       en;
        logic [7:0] op;
        logic [1:0] fb;
        logic [1:0] fc;
    } exp_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [15:0] exp_stall = 16'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    // Drive one op for one cycle, score en/op_out/fwd at the falling edge.
    task automatic step(input string tag, input logic [7:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] c, input logic j,
                        input logic e, input logic [1:0] fb, input logic [1:0] fc);
        exp_t x;
        bus.li_di_op = op;
        bus.li_di_a  = a;
        bus.li_di_b  = b;
        bus.li_di_c  = c;
        bus.jmp      = j;
        sb.push_back(exp_t'{en: e, op: (e ? op : 8'h00), fb: fb, fc: fc});
        @(negedge sys_clk);
        x = sb.pop_front();
        chk({tag, "_en"},  32'(bus.en),           32'(x.en));
        chk({tag, "_op"},  32'(bus.li_di_op_out), 32'(x.op));
        chk({tag, "_fb"},  32'(bus.fwd_b),        32'(x.fb));
        chk({tag, "_fc"},  32'(bus.fwd_c),        32'(x.fc));
        @(posedge sys_clk);
        #1;
        if (!e && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
    endtask

    task automatic drain();
        for (int k = 0; k < 3; k++) step("drain", OP_NOP, 16'd0, 16'd0, 16'd0, 1'b0, 1'b1, 2'd0, 2'd0);
    endtask

    logic issue_lod;

    initial begin
        bus.li_di_op  = OP_ADD;
        bus.li_di_a   = 16'd1;
        bus.li_di_b   = 16'd2;
        bus.li_di_c   = 16'd3;
        bus.jmp       = 1'b0;
        bus2.li_di_op = OP_NOP;
        bus2.li_di_a  = 16'd0;
        bus2.li_di_b  = 16'd0;
        bus2.li_di_c  = 16'd0;
        bus2.jmp      = 1'b0;

        // Reset state, before and after clock edges while held.
        #1 sys_rst = 1'b0;
        #1;
        chk("rst_en",    32'(bus.en),           32'd1);
        chk("rst_op",    32'(bus.li_di_op_out), 32'(OP_ADD));
        chk("rst_fb",    32'(bus.fwd_b),        32'd0);
        chk("rst_fc",    32'(bus.fwd_c),        32'd0);
        chk("rst_cnt",   32'(bus.stall_cnt),    32'd0);
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst2_en",   32'(bus.en),           32'd1);
        chk("rst2_cnt",  32'(bus.stall_cnt),    32'd0);
        sys_rst = 1'b1;

        // ADD r1 then ADD r2,r1,r3 back-to-back.
        step("alu_prod", OP_ADD, 16'd1, 16'd2, 16'd3, 1'b0, 1'b1, 2'd0, 2'd0);
        for (int k = 0; k < ALU_STALLS; k++)
            step("alu_stall", OP_ADD, 16'd2, 16'd1, 16'd3, 1'b0, 1'b0, 2'd0, 2'd0);
        step("alu_issue", OP_ADD, 16'd2, 16'd1, 16'd3, 1'b0, 1'b1,
             (ALU_STALLS == 0) ? FWD_ALU0 : 2'd0, 2'd0);
        chk("alu_cnt", 32'(bus.stall_cnt), 32'(exp_stall));
        drain();

        // LOD r4 then ADD r5,r4,r4.
        step("ld_prod", OP_LOD, 16'd4, 16'd0, 16'd0, 1'b0, 1'b1, 2'd0, 2'd0);
        for (int k = 0; k < LOAD_STALLS; k++)
            step("ld_stall", OP_ADD, 16'd5, 16'd4, 16'd4, 1'b0, 1'b0, 2'd0, 2'd0);
        step("ld_issue", OP_ADD, 16'd5, 16'd4, 16'd4, 1'b0, 1'b1, FWD_LOAD2, FWD_LOAD2);
        chk("ld_cnt", 32'(bus.stall_cnt), 32'(exp_stall));
        drain();

        // Hazard with jmp: passes, counter unchanged, and the op is still recorded.
        step("j_prod", OP_ADD, 16'd6, 16'd7, 16'd7, 1'b0, 1'b1, 2'd0, 2'd0);
        step("j_haz",  OP_ADD, 16'd8, 16'd6, 16'd0, 1'b1, 1'b1, FWD_ALU0, 2'd0);
        chk("j_cnt", 32'(bus.stall_cnt), 32'(exp_stall));
        step("j_rec",  OP_COP, 16'd9, 16'd8, 16'd5, 1'b0, (ALU_STALLS == 0), FWD_ALU0, 2'd0);
        chk("j_rec_cnt", 32'(bus.stall_cnt), 32'(exp_stall));
        drain();

        // Reset while stalled on a load.
        step("r_prod",  OP_LOD, 16'd10, 16'd0,  16'd0,  1'b0, 1'b1, 2'd0, 2'd0);
        step("r_stall", OP_ADD, 16'd11, 16'd10, 16'd10, 1'b0, 1'b0, 2'd0, 2'd0);
        sys_rst = 1'b0;
        #1;
        exp_stall = 16'd0;
        chk("r_en",  32'(bus.en),           32'd1);
        chk("r_op",  32'(bus.li_di_op_out), 32'(OP_ADD));
        chk("r_cnt", 32'(bus.stall_cnt),    32'd0);
        #1 sys_rst = 1'b1;
        step("r_dep", OP_ADD, 16'd11, 16'd10, 16'd10, 1'b0, 1'b1, 2'd0, 2'd0);
        chk("r_dep_cnt", 32'(bus.stall_cnt), 32'd0);

        // Saturation: alternate a load of r12 with a reader of r12 for 70000 cycles.
        issue_lod = 1'b1;
        for (int k = 0; k < 70000; k++) begin
            bus2.li_di_op = issue_lod ? OP_LOD : OP_ADD;
            bus2.li_di_a  = issue_lod ? 16'd12 : 16'd13;
            bus2.li_di_b  = 16'd12;
            bus2.li_di_c  = 16'd12;
            @(negedge sys_clk);
            issue_lod = bus2.en && (bus2.li_di_op == OP_ADD);
            @(posedge sys_clk);
            #1;
        end
        chk("sat_cnt", 32'(bus2.stall_cnt), 32'h0000FFFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
